// File: rtl/seg_link_pkg.sv
// Shared definitions for the serial digit link: frame geometry, link FSM
// states and the hex-to-segment lookup table.
package seg_link_pkg;

    // Payload bits per frame ({addr[1:0], seg[7:0]}) and serial clock pulses
    // per frame (payload plus the trailing latch pulse).
    localparam int FRAME_BITS       = 10;
    localparam int PULSES_PER_FRAME = 11;

    // Width of the phase counter; wide enough for GAP_CYCLES up to 16M.
    localparam int PHASE_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        GAP
    } link_state_e;

    // Segment patterns for hex digits 0..F.
    // Bit order: 0 right-high, 1 top, 2 left-high, 3 left-low, 4 bottom,
    // 5 right-low, 6 middle. Listed F first so that index [n] is digit n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h4E, 7'h5E, 7'h79, 7'h1E,   // F E d C
        7'h7C, 7'h6F, 7'h77, 7'h7F,   // b A 9 8
        7'h23, 7'h7E, 7'h76, 7'h65,   // 7 6 5 4
        7'h73, 7'h5B, 7'h21, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to 7-segment pattern decoder.
module seg_hex_decode
    import seg_link_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/serial_digit_sender.sv
// Serialises (digit address, segment pattern) requests onto a slow two-wire
// clock/data link: 10 data pulses MSB first, one latch pulse, then an idle gap.
// Optional build macro SEG_HEX_DECODE_EN: segData[3:0] is treated as a hex
// nibble and decoded to a segment pattern (segData[7] stays the DP bit).
module serial_digit_sender
    import seg_link_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 240000,
    parameter int unsigned GAP_CYCLES  = 480000
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic [1:0] digitAddr,
    input  logic [7:0] segData,
    input  logic       sendValid,
    output logic       sendReady,
    output logic       busy,
    output logic       serialClockOut,
    output logic       serialDataOut
);

    localparam logic [PHASE_W-1:0] HALF_LAST = PHASE_W'(HALF_PERIOD - 1);
    localparam logic [PHASE_W-1:0] GAP_LAST  = PHASE_W'(GAP_CYCLES - 1);
    localparam logic [3:0]         LAST_BIT  = 4'(PULSES_PER_FRAME - 1);

    link_state_e state;
    link_state_e state_next;

    logic [PHASE_W-1:0]    phase_cnt;
    logic [3:0]            bit_idx;
    logic [FRAME_BITS-1:0] shift_word;
    logic [FRAME_BITS-1:0] frame_word;
    logic                  data_bit;
    logic                  accept;
    logic                  phase_done;

`ifdef SEG_HEX_DECODE_EN
    logic [6:0] hex_seg;

    seg_hex_decode u_hex_decode (
        .nibble (segData[3:0]),
        .seg    (hex_seg)
    );

    assign frame_word = {digitAddr, segData[7], hex_seg};
`else
    assign frame_word = {digitAddr, segData};
`endif

    assign accept         = sendValid && (state == IDLE);
    assign sendReady      = (state == IDLE);
    assign busy           = (state != IDLE);
    assign serialClockOut = (state == HIGH);
    assign serialDataOut  = data_bit;

    // State register; reset forces the link lines low without waiting for a clock.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each LOW/HIGH phase and the gap end on their terminal count.
    always_comb begin
        state_next = state;
        phase_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                phase_done = (phase_cnt == HALF_LAST);
                if (phase_done) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                phase_done = (phase_cnt == HALF_LAST);
                if (phase_done) begin
                    state_next = (bit_idx == LAST_BIT) ? GAP : LOW;
                end
            end
            GAP: begin
                phase_done = (phase_cnt == GAP_LAST);
                if (phase_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Phase counter restarts at zero on every state change so each phase lasts exactly N cycles.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            phase_cnt <= '0;
        end else if (state_next != state) begin
            phase_cnt <= '0;
        end else if (state != IDLE) begin
            phase_cnt <= phase_cnt + PHASE_W'(1);
        end
    end

    // Data path: the next bit is loaded as LOW is entered so it is stable across the whole pulse;
    // zeros shifted in behind the payload make the latch slot and gap drive 0.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            bit_idx    <= '0;
            shift_word <= '0;
            data_bit   <= 1'b0;
        end else if (accept) begin
            bit_idx    <= '0;
            data_bit   <= frame_word[FRAME_BITS-1];
            shift_word <= {frame_word[FRAME_BITS-2:0], 1'b0};
        end else if ((state == HIGH) && phase_done) begin
            if (bit_idx == LAST_BIT) begin
                data_bit <= 1'b0;
            end else begin
                bit_idx    <= bit_idx + 4'd1;
                data_bit   <= shift_word[FRAME_BITS-1];
                shift_word <= {shift_word[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_serial_digit_sender.sv
// Scoreboard bench for serial_digit_sender: stimulus pushes expected 11-bit
// frames, a monitor reassembles frames from the serial lines and compares.
// Honours SEG_HEX_DECODE_EN for the expected segment pattern.
module tb_serial_digit_sender;

    localparam int HP  = 4;
    localparam int GAP = 8;
    localparam int CLK_PERIOD = 10;

    logic       clock;
    logic       resetN;
    logic [1:0] digitAddr;
    logic [7:0] segData;
    logic       sendValid;
    logic       sendReady;
    logic       busy;
    logic       serialClockOut;
    logic       serialDataOut;

    int checks;
    int failures;

    logic [10:0] exp_q[$];
    logic [10:0] rx_bits;
    logic [10:0] exp_frame;
    int          bit_cnt;
    int          frames_rx;
    int          unstable;
    logic        prev_sclk;
    logic        held_bit;

    serial_digit_sender #(
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clock          (clock),
        .resetN         (resetN),
        .digitAddr      (digitAddr),
        .segData        (segData),
        .sendValid      (sendValid),
        .sendReady      (sendReady),
        .busy           (busy),
        .serialClockOut (serialClockOut),
        .serialDataOut  (serialDataOut)
    );

    // Free-running system clock.
    initial clock = 1'b0;
    always #(CLK_PERIOD/2) clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pattern the link should carry for a given segData input.
    function automatic logic [7:0] expected_seg(input logic [7:0] seg);
`ifdef SEG_HEX_DECODE_EN
        logic [6:0] pat;
        case (seg[3:0])
            4'h0: pat = 7'h3F;  4'h1: pat = 7'h21;  4'h2: pat = 7'h5B;  4'h3: pat = 7'h73;
            4'h4: pat = 7'h65;  4'h5: pat = 7'h76;  4'h6: pat = 7'h7E;  4'h7: pat = 7'h23;
            4'h8: pat = 7'h7F;  4'h9: pat = 7'h77;  4'hA: pat = 7'h6F;  4'hB: pat = 7'h7C;
            4'hC: pat = 7'h1E;  4'hD: pat = 7'h79;  4'hE: pat = 7'h5E;  default: pat = 7'h4E;
        endcase
        return {seg[7], pat};
`else
        return seg;
`endif
    endfunction

    // Monitor: reassemble frames on serial clock rising edges and score them.
    always @(negedge clock) begin
        if (!resetN) begin
            bit_cnt   = 0;
            prev_sclk = 1'b0;
            unstable  = 0;
        end else begin
            if (serialClockOut && !prev_sclk) begin
                rx_bits  = {rx_bits[9:0], serialDataOut};
                held_bit = serialDataOut;
                bit_cnt++;
                if (bit_cnt == 11) begin
                    frames_rx++;
                    bit_cnt = 0;
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_frame", {21'd0, rx_bits}, 32'hFFFF_FFFF);
                    end else begin
                        exp_frame = exp_q.pop_front();
                        check_output("frame_bits", {21'd0, rx_bits}, {21'd0, exp_frame});
                    end
                    check_output("data_stable_high", unstable, 0);
                    unstable = 0;
                end
            end else if (serialClockOut && prev_sclk && (serialDataOut !== held_bit)) begin
                unstable++;
            end
            prev_sclk = serialClockOut;
        end
    end

    task automatic wait_ready(input int limit);
        int n;
        n = 0;
        while (!sendReady && n < limit) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!sendReady) check_output("ready_timeout", 0, 1);
    endtask

    // Present a request and hold sendValid through the accept edge; returns the accept time.
    task automatic apply_stimulus(input logic [1:0] addr, input logic [7:0] seg, output time acc_time);
        wait_ready(300);
        digitAddr = addr;
        segData   = seg;
        sendValid = 1'b1;
        @(posedge clock);
        acc_time = $time;
        exp_q.push_back({addr, expected_seg(seg), 1'b0});
        #1;
    endtask

    initial begin
        time t0, t1, t2;
        int  n;
        int  bad;

        checks    = 0;
        failures  = 0;
        bit_cnt   = 0;
        frames_rx = 0;
        unstable  = 0;
        prev_sclk = 1'b0;
        held_bit  = 1'b0;
        rx_bits   = '0;
        resetN    = 1'b0;
        digitAddr = 2'd0;
        segData   = 8'h00;
        sendValid = 1'b0;

        repeat (3) @(posedge clock);
        #1 resetN = 1'b1;

        $display("[TB] reset state and idle");
        check_output("reset_ready", {31'd0, sendReady}, 1);
        check_output("reset_busy", {31'd0, busy}, 0);
        check_output("reset_sclk", {31'd0, serialClockOut}, 0);
        check_output("reset_sdata", {31'd0, serialDataOut}, 0);
        bad = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (serialClockOut || serialDataOut || !sendReady || busy) bad++;
        end
        check_output("idle_quiet", bad, 0);

        $display("[TB] single frame addr=2 seg=0x5B");
        apply_stimulus(2'd2, 8'h5B, t0);
        sendValid = 1'b0;
        check_output("accept_busy", {31'd0, busy}, 1);
        check_output("accept_ready_low", {31'd0, sendReady}, 0);
        n = 0;
        while (!sendReady && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_output("frame_length", n, 22*HP + GAP);

        $display("[TB] back-to-back frames");
        apply_stimulus(2'd0, 8'h3C, t0);
        apply_stimulus(2'd1, 8'h81, t1);
        apply_stimulus(2'd3, 8'h66, t2);
        sendValid = 1'b0;
        check_output("b2b_interval_1", int'((t1 - t0) / CLK_PERIOD), 22*HP + GAP + 1);
        check_output("b2b_interval_2", int'((t2 - t1) / CLK_PERIOD), 22*HP + GAP + 1);

        $display("[TB] inputs changed mid-frame, sendValid while busy");
        apply_stimulus(2'd1, 8'hA5, t0);
        sendValid = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        digitAddr = 2'd3;
        segData   = 8'h00;
        repeat (10) @(posedge clock);
        #1 sendValid = 1'b1;
        repeat (5) @(posedge clock);
        #1 sendValid = 1'b0;
        wait_ready(300);

        $display("[TB] segment pattern 0x8A");
        apply_stimulus(2'd0, 8'h8A, t0);
        sendValid = 1'b0;
        wait_ready(300);

        $display("[TB] reset during bit 5 high phase");
        apply_stimulus(2'd3, 8'hFF, t0);
        sendValid = 1'b0;
        repeat (10*HP + HP) @(posedge clock);
        #1;
        check_output("bit5_sclk_high", {31'd0, serialClockOut}, 1);
        check_output("bit5_data_high", {31'd0, serialDataOut}, 1);
        #1 resetN = 1'b0;
        #1;
        check_output("async_reset_sclk", {31'd0, serialClockOut}, 0);
        check_output("async_reset_sdata", {31'd0, serialDataOut}, 0);
        exp_q.delete();
        repeat (3) @(posedge clock);
        #1 resetN = 1'b1;
        #1;
        check_output("post_reset_ready", {31'd0, sendReady}, 1);
        check_output("post_reset_busy", {31'd0, busy}, 0);

        repeat (30) @(posedge clock);
        #1;
        check_output("queue_drained", exp_q.size(), 0);
        check_output("no_partial_frame", bit_cnt, 0);
        check_output("frames_received", frames_rx, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_digit_sender.md
Name: serial_digit_sender

Overview:
- Upstream feeder for the four-digit 7-segment display controller.
- Takes one (digit address, segment pattern) request per handshake.
- Serialises each request as a 10-bit frame followed by one latch pulse, on a slow two-wire link: serialClockOut / serialDataOut.
- Link timing suits the receiver's coarse input sampling: it samples every 65536 system clocks through a two-stage filter, with 11 clock pulses per frame.

Parameters:
- HALF_PERIOD, 240000: system clocks per serial-clock half-phase (low or high). Must be ≥ 131072 so each level spans ≥2 receiver samples.
- GAP_CYCLES, 480000: system clocks of idle-low after the latch pulse before the next request is accepted.

Ports:
- clock  in  1  system clock, 24 MHz
- resetN  in  1  asynchronous reset, active low
- digitAddr  in  2  target digit, 0..3
- segData  in  8  segment pattern, bit7 = DP
- sendValid  in  1  request valid
- sendReady  out  1  high only in IDLE; request accepted when sendValid && sendReady on a clock edge
- busy  out  1  high from the accept edge until return to IDLE
- serialClockOut  out  1  serial clock to display controller; idle low
- serialDataOut  out  1  serial data to display controller; idle low

Behaviour:
- Reset (async, resetN=0): state IDLE; sendReady=1, busy=0, serialClockOut=0, serialDataOut=0; counters and shift register cleared.
- Clock and reset are named and behave exactly as in "Already decided": one clock, `clock`; reset is asynchronous and active-low, `resetN`.
- Frame word = {digitAddr, segData}, 10 bits, sent MSB first: addr[1], addr[0], seg[7] … seg[0].
- Bit slot 10 is the latch pulse, with data driven 0. The receiver shifts on rising edges 1–10 and commits on rising edge 11.
- States and transitions:
  - IDLE: on accept, capture the word, set bitIdx=0, go to LOW. sendReady falls the cycle after accept.
  - LOW: serialClockOut=0. serialDataOut is updated to the current bit on the first cycle of LOW only, so data is stable for the whole low and high phases. Stay HALF_PERIOD cycles, then go to HIGH.
  - HIGH: serialClockOut=1 for HALF_PERIOD cycles. Then, if bitIdx==10, go to GAP; else bitIdx++ and go to LOW.
  - GAP: serialClockOut=0, serialDataOut=0 for GAP_CYCLES, then go to IDLE.
- Frame length is exactly 22·HALF_PERIOD + GAP_CYCLES cycles from the accept edge to sendReady=1.
- Phase counter is 24-bit and counts 0..N-1. Terminal count is N-1; no off-by-one — each phase is exactly N cycles.
- sendValid while busy: ignored, not queued. Inputs are sampled only on the accept edge; later changes have no effect on the frame.
- Accept on the same edge that GAP ends: not possible. IDLE lasts at least 1 cycle with sendReady=1.
- Reset mid-frame: outputs drop low immediately. The receiver's pulse count is then misaligned. Recovering it is the system's responsibility: power-cycle both ends together. This block does not attempt resync.

Optional Feature:
- Macro: SEG_HEX_DECODE_EN
- Defined: segData[3:0] is a hex nibble and segData[7] is DP; segData[6:4] are ignored. The transmitted pattern is {segData[7], table[nibble][6:0]} with:
  - 0=3F, 1=21, 2=5B, 3=73, 4=65, 5=76, 6=7E, 7=23
  - 8=7F, 9=77, A=6F, b=7C, C=1E, d=79, E=5E, F=4E
  - Segment bit order: bit0 right-high, bit1 top, bit2 left-high, bit3 left-low, bit4 bottom, bit5 right-low, bit6 middle.
  - Decode is combinational, applied before capture. Latency is unchanged.
- Undefined: segData is transmitted raw.

Decomposition:
- Package seg_link_pkg holds:
  - FRAME_BITS=10 and PULSES_PER_FRAME=11
  - state enum {IDLE, LOW, HIGH, GAP}
  - the 16-entry hex segment table constants
- Sub-module seg_hex_decode: 4-bit nibble → 7-bit pattern. Instantiated only under SEG_HEX_DECODE_EN.

Test Plan (HALF_PERIOD=4, GAP_CYCLES=8 unless stated):
- Reset release, no request -> sendReady=1, busy=0, both serial lines 0 indefinitely.
- Request addr=2, seg=0x5B -> 11 rising edges on serialClockOut. Data sampled at each rising edge = 1,0,0,1,0,1,1,0,1,1,0. sendReady returns exactly 96 cycles after accept.
- sendValid held high for 3 back-to-back frames (addr 0,1,3) -> exactly 3 frames, each separated by 8 low cycles plus 1 IDLE cycle. No extra pulses.
- Change digitAddr/segData mid-frame -> transmitted bits match the accept-edge values only.
- Assert resetN low during bit 5 HIGH -> serialClockOut and serialDataOut are 0 in the same cycle, before any clock edge. After release: IDLE, sendReady=1.
- With SEG_HEX_DECODE_EN, segData=0x8A -> transmitted pattern 0xEF. Also run a scoreboard loopback through a behavioural model of the display receiver, HALF_PERIOD=131072: digit register updated correctly.
